sfpp_i2c_sequencer: RTL and testbench
=====================================

// Module: sfpp_i2c_sequencer
// PURPOSE
//  Autonomous sequencer for the SFP+ port 1 management bus. Drives the 8-bit Wishbone register file of
//  i2c_master_top (prescale, control, TX/RX, command/status) to do a random-address burst read from the
//  SFP+ module: write the register pointer, repeated START, read LEN bytes. Sits between an on-chip
//  requester (link monitor) and the I2C core, all on okClk. Host Wishbone access to the core is muxed
//  in upstream while busy=0.
// PARAMETERS
//  PRESCALE      16'd199  I2C core prescaler, written to PRERlo/PRERhi on each request (100 kHz SCL at okClk)
//  POLL_TIMEOUT  65535    max clk cycles one byte transfer may take (TIP=1) before a timeout abort
// PORTS
//  clk         in   1   okClk; all logic on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  start       in   1   one-cycle request pulse; ignored while busy=1
//  dev_addr    in   7   7-bit I2C device address (0x50 EEPROM, 0x51 DOM); sampled at accepted start
//  reg_addr    in   8   first register to read; sampled at accepted start
//  len         in   8   byte count; 0 is treated as 256
//  mod_abs     in   1   SFP+ module-absent pin, 1 = no module
//  busy        out  1   high from the accepted start until the done/error pulse
//  done        out  1   one-cycle pulse: burst finished, all bytes delivered
//  error       out  1   one-cycle pulse: burst aborted; err_code valid for that cycle and held until next start
//  err_code    out  2   0 NACK, 1 arbitration lost, 2 timeout, 3 module absent
//  rd_valid    out  1   one-cycle pulse per received byte
//  rd_data     out  8   received byte, valid with rd_valid
//  rd_index    out  8   byte offset within the burst (0..len-1), valid with rd_valid
//  wbm_adr_o   out  3   Wishbone address to the I2C core
//  wbm_dat_o   out  8   Wishbone write data
//  wbm_dat_i   in   8   Wishbone read data
//  wbm_we_o    out  1   Wishbone write enable
//  wbm_stb_o   out  1   Wishbone strobe
//  wbm_cyc_o   out  1   Wishbone cycle
//  wbm_ack_i   in   1   Wishbone acknowledge
// BEHAVIOUR
//  Reset: all outputs 0, err_code=0, FSM in IDLE. Reset mid-burst aborts at once; no STOP is issued.
//  WB rule: one single access at a time. cyc=stb=1 with adr/dat/we stable until ack; both drop the cycle
//   after ack. Next access starts no earlier than one cycle after that. No pipelining.
//  Core registers used: 0 PRERlo, 1 PRERhi, 2 CTR (EN=bit7), 3 TXR (write) / RXR (read), 4 CR (write) / SR (read).
//   CR bits: STA=7, STO=6, RD=5, WR=4, ACK=3, IACK=0. SR bits: RxACK=7, AL=5, TIP=1.
//  Start handling: a start in IDLE with mod_abs=1 sets busy for exactly 1 cycle, then gives error with code 3.
//   No WB traffic in this case.
//  FSM, each W = one WB write:
//   IDLE -> PRE_LO W(0,PRESCALE[7:0]) -> PRE_HI W(1,PRESCALE[15:8]) -> EN W(2,0x80)
//   -> TXA W(3,{dev,0}) -> CMD W(4,0x90) -> POLL
//   -> TXR W(3,reg_addr) -> CMD W(4,0x10) -> POLL
//   -> TXA2 W(3,{dev,1}) -> CMD W(4,0x90) -> POLL
//   -> RDC W(4, last ? 0x68 : 0x20) -> POLL -> RXR read(3) -> rd_valid
//   -> loop to RDC until count==len -> DONE
//  Read command: last byte sends NACK+STOP (0x68); earlier bytes send ACK (0x20).
//  POLL: read SR repeatedly until TIP=0. Timeout counter resets at each POLL entry.
//   AL=1 -> abort with code 1.
//   RxACK=1 after an address or pointer byte -> abort with code 0.
//   Counter reaching POLL_TIMEOUT -> abort with code 2.
//   RxACK is ignored after read bytes.
//  Abort (codes 0/2): W(4,0x40) STOP. Poll SR up to POLL_TIMEOUT cycles for TIP=0, then error pulse.
//   Code 1 skips the STOP. Abort ends with W(2,0x00) to disable the core. DONE also ends with W(2,0x00).
//  done/error are asserted in the same cycle busy falls. start is accepted again from the next cycle.
//  Byte counter is 9 bits so len=0 gives 256 reads; rd_index wraps 255 -> 0 only at the end of the burst.
// TESTING
//  EEPROM model at 0x50 with mem[i]=i^0xA5; start dev=0x50 reg=0x14 len=4 -> rd_data 0xB1,0xB0,0xB3,0xB2, idx 0..3, done once.
//  No device at 0x51 (address NACK) -> STOP W(4,0x40) issued, error with err_code=0, 0 rd_valid, busy low after.
//  mod_abs=1 then start -> error with code 3 one cycle after start, wbm_cyc_o stays 0.
//  SR forced TIP=1 forever, POLL_TIMEOUT=100 -> error with code 2 within about 250 cycles.
//  len=0 -> exactly 256 rd_valid; the last read command is 0x68; done once.
//  rst_n low mid-read -> all outputs 0 the same cycle. Back-to-back start the cycle after done is accepted.
//  Also check wbm_ack_i delayed 0..3 cycles.

Source files
------------

// File: rtl/sfpp_i2c_sequencer.sv
// Burst-read sequencer for the SFP+ management bus: drives the i2c_master_top Wishbone
// register file through pointer write, repeated START and LEN byte reads, with abort handling.
module sfpp_i2c_sequencer #(
  parameter logic [15:0] PRESCALE     = 16'd199,
  parameter int unsigned POLL_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] len,
  input  logic       mod_abs,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [7:0] rd_index,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);
  localparam logic [16:0] TMO = 17'(POLL_TIMEOUT);
  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  typedef enum logic [4:0] {
    S_IDLE, S_ABS, S_PRE_LO, S_PRE_HI, S_EN, S_TXA, S_CMDA, S_POLLA,
    S_TXR, S_CMDR, S_POLLR, S_TXA2, S_CMDA2, S_POLLA2, S_RDC, S_POLLD,
    S_RXR, S_STOP, S_POLLS, S_DIS
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d, abort_q, abort_d;
  logic [1:0]  err_q, err_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d, rd_index_q, rd_index_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [8:0]  len_q, len_d, cnt_q, cnt_d;
  logic [16:0] tmo_q, tmo_d;
  logic        acc_we, is_poll, last, timeout;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat;

  assign last    = (cnt_q == len_q - 9'd1);
  assign timeout = (tmo_q >= TMO);
  assign is_poll = (state_q == S_POLLA) || (state_q == S_POLLR) || (state_q == S_POLLA2) ||
                   (state_q == S_POLLD) || (state_q == S_POLLS);
  assign tmo_d   = is_poll ? tmo_q + {16'd0, ~&tmo_q} : 17'd0;

  // Register access each state performs on the core
  always_comb begin
    acc_we  = 1'b1;
    acc_adr = 3'd4;
    acc_dat = 8'h00;
    case (state_q)
      S_PRE_LO:          begin acc_adr = 3'd0; acc_dat = PRESCALE[7:0]; end
      S_PRE_HI:          begin acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; end
      S_EN:              begin acc_adr = 3'd2; acc_dat = 8'h80; end
      S_TXA:             begin acc_adr = 3'd3; acc_dat = {dev_q, 1'b0}; end
      S_CMDA, S_CMDA2:   acc_dat = 8'h90;
      S_TXR:             begin acc_adr = 3'd3; acc_dat = reg_q; end
      S_CMDR:            acc_dat = 8'h10;
      S_TXA2:            begin acc_adr = 3'd3; acc_dat = {dev_q, 1'b1}; end
      S_RDC:             acc_dat = last ? 8'h68 : 8'h20;
      S_STOP:            acc_dat = 8'h40;
      S_DIS:             acc_adr = 3'd2;
      S_RXR:             begin acc_we = 1'b0; acc_adr = 3'd3; end
      S_POLLA, S_POLLR, S_POLLA2, S_POLLD, S_POLLS: acc_we = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_d      = err_q;
    abort_d    = abort_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        busy_d  = 1'b1;
        err_d   = 2'd0;
        abort_d = 1'b0;
        dev_d   = dev_addr;
        reg_d   = reg_addr;
        len_d   = (len == 8'd0) ? 9'd256 : {1'b0, len};
        cnt_d   = 9'd0;
        state_d = mod_abs ? S_ABS : S_PRE_LO;
      end
    end else if (state_q == S_ABS) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      error_d = 1'b1;
      err_d   = 2'd3;
    end else if (!cyc_q) begin
      // Launching only when the bus is idle leaves one dead cycle after every ack
      cyc_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_dat;
    end else if (wbm_ack_i) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      case (state_q)
        S_PRE_LO: state_d = S_PRE_HI;
        S_PRE_HI: state_d = S_EN;
        S_EN:     state_d = S_TXA;
        S_TXA:    state_d = S_CMDA;
        S_CMDA:   state_d = S_POLLA;
        S_TXR:    state_d = S_CMDR;
        S_CMDR:   state_d = S_POLLR;
        S_TXA2:   state_d = S_CMDA2;
        S_CMDA2:  state_d = S_POLLA2;
        S_RDC:    state_d = S_POLLD;
        S_STOP:   state_d = S_POLLS;
        S_POLLA, S_POLLR, S_POLLA2, S_POLLD: begin
          if (wbm_dat_i[SR_AL]) begin
            err_d = 2'd1; abort_d = 1'b1; state_d = S_DIS;
          end else if (!wbm_dat_i[SR_TIP]) begin
            if (state_q != S_POLLD && wbm_dat_i[SR_RXACK]) begin
              err_d = 2'd0; abort_d = 1'b1; state_d = S_STOP;
            end else begin
              case (state_q)
                S_POLLA:  state_d = S_TXR;
                S_POLLR:  state_d = S_TXA2;
                S_POLLA2: state_d = S_RDC;
                default:  state_d = S_RXR;
              endcase
            end
          end else if (timeout) begin
            err_d = 2'd2; abort_d = 1'b1; state_d = S_STOP;
          end
        end
        S_POLLS:  if (!wbm_dat_i[SR_TIP] || timeout) state_d = S_DIS;
        S_RXR: begin
          rd_valid_d = 1'b1;
          rd_data_d  = wbm_dat_i;
          rd_index_d = cnt_q[7:0];
          cnt_d      = cnt_q + 9'd1;
          state_d    = last ? S_DIS : S_RDC;
        end
        S_DIS: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = ~abort_q;
          error_d = abort_q;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= 2'd0;
      abort_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      rd_index_q <= 8'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 3'd0;
      dat_q      <= 8'd0;
      dev_q      <= 7'd0;
      reg_q      <= 8'd0;
      len_q      <= 9'd0;
      cnt_q      <= 9'd0;
      tmo_q      <= 17'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_index  = rd_index_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cyc_o = cyc_q;
endmodule

// File: tb/tb_sfpp_i2c_sequencer.sv
// Bench for sfpp_i2c_sequencer: byte-level I2C core model with an EEPROM at 0x50
// (mem[i] = i ^ 0xA5) and scoreboards for Wishbone writes, read bytes and end events.
module tb_sfpp_i2c_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, mod_abs;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, len;
  logic       busy, done, error, rd_valid;
  logic [1:0] err_code;
  logic [7:0] rd_data, rd_index;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o, wbm_dat_i;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

  always #5 clk = ~clk;

  sfpp_i2c_sequencer #(.PRESCALE(16'd199), .POLL_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .len(len), .mod_abs(mod_abs), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  int         rv_cnt = 0;
  int         used;
  bit         cyc_seen = 1'b0;
  bit         tip_forever = 1'b0;
  bit         rand_dly = 1'b0;
  logic [10:0] wq[$];
  logic [15:0] rq[$];
  logic [3:0]  evq[$];

  // I2C core model
  logic [7:0] m_txr, m_rxr, m_ptr, m_last_rd;
  logic       m_rxack;
  int         m_tip, m_dly, m_wcnt;
  logic [7:0] m_sr;
  assign m_sr      = {m_rxack, 1'b0, 1'b0, 3'b000, (m_tip != 0) || tip_forever, 1'b0};
  assign wbm_dat_i = (wbm_adr_o == 3'd4) ? m_sr : (wbm_adr_o == 3'd3) ? m_rxr : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0; m_wcnt <= 0; m_tip <= 0; m_dly <= 0;
      m_rxack <= 1'b0; m_ptr <= 8'd0; m_txr <= 8'd0; m_rxr <= 8'd0; m_last_rd <= 8'd0;
    end else begin
      if (m_tip > 0) m_tip <= m_tip - 1;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
        if (m_wcnt >= m_dly) begin
          wbm_ack_i <= 1'b1;
          m_wcnt    <= 0;
          m_dly     <= rand_dly ? int'($urandom_range(0, 3)) : 0;
          if (wbm_we_o && wbm_adr_o == 3'd3) m_txr <= wbm_dat_o;
          if (wbm_we_o && wbm_adr_o == 3'd4) begin
            if (wbm_dat_o[7] && wbm_dat_o[4]) begin
              m_rxack <= (m_txr[7:1] != 7'h50); m_tip <= 4;
            end else if (wbm_dat_o[4]) begin
              m_ptr <= m_txr; m_rxack <= 1'b0; m_tip <= 4;
            end else if (wbm_dat_o[5]) begin
              m_rxr <= m_ptr ^ 8'hA5; m_ptr <= m_ptr + 8'd1; m_last_rd <= wbm_dat_o; m_tip <= 4;
            end else if (wbm_dat_o[6]) begin
              m_tip <= 4;
            end
          end
        end else begin
          m_wcnt <= m_wcnt + 1;
        end
      end else begin
        wbm_ack_i <= 1'b0;
        m_wcnt    <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    logic [10:0] ew;
    logic [15:0] er;
    logic [3:0]  ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wbm_cyc_o) cyc_seen = 1'b1;
        if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) begin
          if (wq.size() != 0) ew = wq.pop_front(); else ew = 'x;
          chk("wb_write", {21'd0, wbm_adr_o, wbm_dat_o}, {21'd0, ew});
        end
        if (rd_valid) begin
          rv_cnt++;
          if (rq.size() != 0) er = rq.pop_front(); else er = 'x;
          chk("rd_byte", {16'd0, rd_index, rd_data}, {16'd0, er});
        end
        if (done || error) begin
          if (evq.size() != 0) ee = evq.pop_front(); else ee = 'x;
          chk("end_event", {28'd0, error, done, error ? err_code : 2'b00}, {28'd0, ee});
        end
      end
    end
  end

  task automatic push_prefix(input logic [6:0] d);
    wq.push_back({3'd0, 8'hC7});
    wq.push_back({3'd1, 8'h00});
    wq.push_back({3'd2, 8'h80});
    wq.push_back({3'd3, d, 1'b0});
    wq.push_back({3'd4, 8'h90});
  endtask

  task automatic push_burst(input logic [6:0] d, input logic [7:0] r, input int n);
    logic [7:0] a;
    push_prefix(d);
    wq.push_back({3'd3, r});
    wq.push_back({3'd4, 8'h10});
    wq.push_back({3'd3, d, 1'b1});
    wq.push_back({3'd4, 8'h90});
    for (int i = 0; i < n; i++) begin
      wq.push_back({3'd4, (i == n - 1) ? 8'h68 : 8'h20});
      a = r + 8'(i);
      rq.push_back({8'(i), a ^ 8'hA5});
    end
    wq.push_back({3'd2, 8'h00});
    evq.push_back(4'b0100);
  endtask

  task automatic push_abort(input logic [6:0] d, input logic [1:0] code);
    push_prefix(d);
    if (code != 2'd1) wq.push_back({3'd4, 8'h40});
    wq.push_back({3'd2, 8'h00});
    evq.push_back({2'b10, code});
  endtask

  task automatic do_start(input logic [6:0] d, input logic [7:0] r, input logic [7:0] l);
    dev_addr = d; reg_addr = r; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || error) && n < budget);
    chk("end_seen", {31'd0, done || error}, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mod_abs = 1'b0; dev_addr = 7'd0; reg_addr = 8'd0; len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {26'd0, busy, done, error, err_code, rd_valid}, 0);
    chk("rst_rd", {16'd0, rd_data, rd_index}, 0);
    chk("rst_wb", {15'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // EEPROM burst: expects B1, B0, B3, B2 at index 0..3
    push_burst(7'h50, 8'h14, 4);
    rv_cnt = 0;
    do_start(7'h50, 8'h14, 8'd4);
    @(negedge clk);
    chk("t1_busy", {31'd0, busy}, 1);
    wait_end(2000, used);
    chk("t1_done", {30'd0, done, error}, 2'b10);
    chk("t1_rdcount", rv_cnt, 4);
    @(posedge clk); #1;
    chk("t1_idle", {31'd0, busy}, 0);

    // Address NACK at 0x51
    push_abort(7'h51, 2'd0);
    rv_cnt = 0;
    do_start(7'h51, 8'h00, 8'd2);
    wait_end(2000, used);
    chk("t2_err_code", {30'd0, err_code}, 0);
    chk("t2_rdcount", rv_cnt, 0);
    @(posedge clk); #1;
    chk("t2_idle", {31'd0, busy}, 0);

    // Module absent
    evq.push_back({2'b10, 2'd3});
    cyc_seen = 1'b0;
    mod_abs  = 1'b1;
    do_start(7'h50, 8'h00, 8'd1);
    @(negedge clk);
    chk("t3_busy1", {30'd0, busy, error}, 2'b10);
    @(negedge clk);
    chk("t3_err", {28'd0, busy, error, err_code}, 4'b0111);
    repeat (4) @(negedge clk);
    chk("t3_hold_code", {30'd0, err_code}, 3);
    chk("t3_no_wb", {31'd0, cyc_seen}, 0);
    mod_abs = 1'b0;
    @(posedge clk); #1;

    // TIP stuck high: timeout abort
    tip_forever = 1'b1;
    push_abort(7'h50, 2'd2);
    do_start(7'h50, 8'h00, 8'd1);
    wait_end(400, used);
    chk("t4_err_code", {30'd0, err_code}, 2);
    chk("t4_latency", {31'd0, used <= 260}, 1);
    tip_forever = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // len=0 means 256 bytes, with random ack latency
    rand_dly = 1'b1;
    push_burst(7'h50, 8'hF0, 256);
    rv_cnt = 0;
    do_start(7'h50, 8'hF0, 8'd0);
    wait_end(20000, used);
    chk("t5_done", {30'd0, done, error}, 2'b10);
    chk("t5_rdcount", rv_cnt, 256);
    chk("t5_last_cmd", {24'd0, m_last_rd}, 8'h68);
    rand_dly = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: second start in the cycle after done
    push_burst(7'h50, 8'h00, 1);
    push_burst(7'h50, 8'h02, 2);
    rv_cnt = 0;
    do_start(7'h50, 8'h00, 8'd1);
    wait_end(2000, used);
    @(posedge clk); #1;
    do_start(7'h50, 8'h02, 8'd2);
    @(negedge clk);
    chk("t6_b2b_busy", {31'd0, busy}, 1);
    wait_end(2000, used);
    chk("t6_rdcount", rv_cnt, 3);

    // Reset in the middle of a read burst
    @(posedge clk); #1;
    push_burst(7'h50, 8'h00, 8);
    rv_cnt = 0;
    do_start(7'h50, 8'h00, 8'd8);
    used = 0;
    while (rv_cnt < 2 && used < 2000) begin
      @(negedge clk);
      used++;
    end
    chk("t7_reached", {31'd0, rv_cnt >= 2}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_ctl", {26'd0, busy, done, error, err_code, rd_valid}, 0);
    chk("t7_rst_wb", {15'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, 0);
    wq.delete(); rq.delete(); evq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_burst(7'h50, 8'h30, 2);
    rv_cnt = 0;
    do_start(7'h50, 8'h30, 8'd2);
    wait_end(2000, used);
    chk("t7_recover", {30'd0, done, error}, 2'b10);
    chk("t7_rdcount", rv_cnt, 2);

    @(posedge clk); #1;
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("evq_empty", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
